// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin 4:1 mux arbiter.
package rr_mux_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } state_e;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
    logic [3:0] oh;
    oh      = 4'b0000;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux4_cell.sv
// Single-bit 4:1 mux cell in sum-of-products form.
module mux4_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  input  logic d_i,
  input  logic s1_i,
  input  logic s0_i,
  output logic y_o
);

  assign y_o = (a_i & ~s1_i & ~s0_i) | (b_i & ~s1_i & s0_i) |
               (c_i &  s1_i & ~s0_i) | (d_i &  s1_i & s0_i);

endmodule

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set bit of (req & mask) scanning ptr, ptr+1, ... mod 4.
module rr_pick4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  input  logic [3:0] mask_i,
  output logic [1:0] winner_o,
  output logic       found_o
);

  logic [3:0] cand;
  assign cand = req_i & mask_i;

  // Scan from farthest to nearest so the lowest offset from ptr wins.
  always_comb begin
    winner_o = ptr_i;
    found_o  = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (cand[ptr_i + 2'(k)]) begin
        winner_o = ptr_i + 2'(k);
        found_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter_4x1.sv
// Round-robin arbiter sharing one 4:1 select path, with bounded hold and direct handoff.
module rr_mux_arbiter_4x1
  import rr_mux_pkg::*;
#(
  parameter int unsigned W        = 1,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [3:0]   req_i,
  input  logic [W-1:0] din_a_i,
  input  logic [W-1:0] din_b_i,
  input  logic [W-1:0] din_c_i,
  input  logic [W-1:0] din_d_i,
  output logic [3:0]   grant_o,
  output logic         s1_o,
  output logic         s0_o,
  output logic         busy_o,
  output logic [W-1:0] y_o
);

  localparam int unsigned     CntW   = $clog2(MAX_HOLD + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_HOLD);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  state_e          state_q, state_d;
  logic [3:0]      grant_q, grant_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [3:0] pick_mask;
  logic [1:0] winner;
  logic       found;
  logic       own_req;

  assign own_req   = req_i[sel_q];
  // While granting, ptr == owner+1, so masking the owner only matters on timeout.
  assign pick_mask = (state_q == StGrant) ? ~idx_to_onehot(sel_q) : 4'hF;

  rr_pick4 u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .mask_i  (pick_mask),
    .winner_o(winner),
    .found_o (found)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StGrant;
          grant_d = idx_to_onehot(winner);
          sel_d   = winner;
          ptr_d   = winner + 2'd1;
          cnt_d   = CntOne;
        end
      end
      StGrant: begin
        if (own_req && (cnt_q < CntMax)) begin
          cnt_d = cnt_q + CntOne;
        end else if (found) begin
          grant_d = idx_to_onehot(winner);
          sel_d   = winner;
          ptr_d   = winner + 2'd1;
          cnt_d   = CntOne;
        end else if (own_req) begin
          cnt_d = CntOne;
        end else begin
          // Select lines keep their last value on release.
          state_d = StIdle;
          grant_d = 4'b0000;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      grant_q <= 4'b0000;
      sel_q   <= SEL_A;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_o = grant_q;
  assign s1_o    = sel_q[1];
  assign s0_o    = sel_q[0];
  assign busy_o  = |grant_q;

  logic [W-1:0] mux_y;

  for (genvar i = 0; i < W; i++) begin : g_mux
    mux4_cell u_cell (
      .a_i (din_a_i[i]),
      .b_i (din_b_i[i]),
      .c_i (din_c_i[i]),
      .d_i (din_d_i[i]),
      .s1_i(sel_q[1]),
      .s0_i(sel_q[0]),
      .y_o (mux_y[i])
    );
  end

  assign y_o = mux_y & {W{busy_o}};

endmodule

// File: tb/tb_rr_mux_arbiter_4x1.sv
// Bench for rr_mux_arbiter_4x1: two instances (MAX_HOLD 8 and 2) against a queue-free rule model.
module tb_rr_mux_arbiter_4x1;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] din_a, din_b, din_c, din_d;

  logic [3:0] grant [2];
  logic       s1    [2];
  logic       s0    [2];
  logic       busy  [2];
  logic [3:0] y     [2];

  int tests = 0;
  int fails = 0;

  rr_mux_arbiter_4x1 #(.W(4), .MAX_HOLD(8)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req),
    .din_a_i(din_a), .din_b_i(din_b), .din_c_i(din_c), .din_d_i(din_d),
    .grant_o(grant[0]), .s1_o(s1[0]), .s0_o(s0[0]), .busy_o(busy[0]), .y_o(y[0])
  );

  rr_mux_arbiter_4x1 #(.W(4), .MAX_HOLD(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req),
    .din_a_i(din_a), .din_b_i(din_b), .din_c_i(din_c), .din_d_i(din_d),
    .grant_o(grant[1]), .s1_o(s1[1]), .s0_o(s0[1]), .busy_o(busy[1]), .y_o(y[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner (-1 = nobody), consecutive-hold count, priority start, last select.
  typedef struct {
    int owner;
    int cnt;
    int ptr;
    int sel;
  } mst_t;

  mst_t m [2];

  function automatic int pick(input logic [3:0] r, input int p, input int excl);
    int i;
    for (int k = 0; k < 4; k++) begin
      i = (p + k) % 4;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  function automatic mst_t nxt(input mst_t s, input logic [3:0] r, input int h);
    mst_t n;
    int   w;
    n = s;
    if (s.owner < 0) begin
      w = pick(r, s.ptr, -1);
      if (w >= 0) begin
        n.owner = w; n.cnt = 1; n.ptr = (w + 1) % 4; n.sel = w;
      end
    end else if (r[s.owner] && s.cnt < h) begin
      n.cnt = s.cnt + 1;
    end else begin
      w = pick(r, s.ptr, s.owner);
      if (w >= 0) begin
        n.owner = w; n.cnt = 1; n.ptr = (w + 1) % 4; n.sel = w;
      end else if (r[s.owner]) begin
        n.cnt = 1;
      end else begin
        n.owner = -1;
      end
    end
    return n;
  endfunction

  function automatic logic [3:0] exp_grant(input mst_t s);
    return (s.owner < 0) ? 4'h0 : 4'(1 << s.owner);
  endfunction

  function automatic logic [3:0] exp_y(input mst_t s);
    case (s.owner)
      0:       return din_a;
      1:       return din_b;
      2:       return din_c;
      3:       return din_d;
      default: return 4'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= '{-1, 0, 0, 0};
      m[1] <= '{-1, 0, 0, 0};
    end else begin
      m[0] <= nxt(m[0], req, 8);
      m[1] <= nxt(m[1], req, 2);
    end
  end

  int waitc [2][4];
  int maxw  [2];

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("model_grant%0d", k), grant[k], exp_grant(m[k]));
      chk($sformatf("model_sel%0d", k), {s1[k], s0[k]}, m[k].sel[1:0]);
      chk($sformatf("model_busy%0d", k), busy[k], m[k].owner >= 0);
      chk($sformatf("model_y%0d", k), y[k], exp_y(m[k]));
      maxw[k] = 0;
      for (int i = 0; i < 4; i++) begin
        if (rst_n && req[i] && !grant[k][i]) waitc[k][i]++;
        else waitc[k][i] = 0;
        if (waitc[k][i] > maxw[k]) maxw[k] = waitc[k][i];
      end
      chk($sformatf("wait_bound%0d", k), maxw[k] <= ((k == 0) ? 27 : 9), 1);
    end
  end

  logic [3:0] rr_exp [9];

  initial begin
    for (int k = 0; k < 2; k++) for (int i = 0; i < 4; i++) waitc[k][i] = 0;
    rr_exp = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1};
    rst_n = 1'b0;
    req   = 4'h0;
    din_a = 4'h5; din_b = 4'h6; din_c = 4'h1; din_d = 4'h9;
    repeat (2) @(negedge clk);
    chk("reset_grant", grant[0], 4'h0);
    chk("reset_busy", busy[0], 1'b0);
    chk("reset_y", y[0], 4'h0);
    chk("reset_sel", {s1[0], s0[0]}, 2'b00);
    rst_n = 1'b1;

    // Single requester c.
    req = 4'b0100;
    @(negedge clk);
    chk("single_grant", grant[0], 4'b0100);
    chk("single_sel", {s1[0], s0[0]}, 2'b10);
    chk("single_y", y[0], 4'h1);
    req = 4'b0000;
    @(negedge clk);
    chk("release_busy", busy[0], 1'b0);
    chk("release_y", y[0], 4'h0);
    chk("release_sel_kept", {s1[0], s0[0]}, 2'b10);

    // Asynchronous reset while granting.
    req = 4'b0100;
    @(negedge clk);
    chk("pre_reset_grant", grant[0], 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("async_grant8", grant[0], 4'h0);
    chk("async_busy8", busy[0], 1'b0);
    chk("async_y8", y[0], 4'h0);
    chk("async_grant2", grant[1], 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1111;

    // Round robin: MAX_HOLD=2 instance rotates every 2 cycles; MAX_HOLD=8 holds a for 8.
    for (int t = 0; t < 9; t++) begin
      @(negedge clk);
      chk($sformatf("rr2_step%0d", t + 1), grant[1], rr_exp[t]);
      if (t == 0) chk("rr8_first", grant[0], 4'b0001);
      if (t == 8) chk("rr8_timeout", grant[0], 4'b0010);
    end

    // Back-to-back handoff a -> b.
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0011;
    @(negedge clk);
    chk("handoff_a8", grant[0], 4'b0001);
    chk("handoff_a2", grant[1], 4'b0001);
    req = 4'b0010;
    @(negedge clk);
    chk("handoff_b8", grant[0], 4'b0010);
    chk("handoff_busy8", busy[0], 1'b1);
    chk("handoff_sel8", {s1[0], s0[0]}, 2'b01);
    chk("handoff_y8", y[0], 4'h6);

    // Lone hog on d; b joins after 10 edges and wins on the second timeout.
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1000;
    for (int t = 1; t <= 17; t++) begin
      @(negedge clk);
      chk($sformatf("hog_edge%0d", t), grant[0], (t <= 16) ? 4'b1000 : 4'b0010);
      if (t == 10) req = 4'b1010;
    end

    // Random sweep with requests held for a few cycles at a time.
    for (int t = 0; t < 10000; t++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      din_a = 4'($urandom); din_b = 4'($urandom);
      din_c = 4'($urandom); din_d = 4'($urandom);
    end

    req = 4'b0000;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter_4x1.md
Name: rr_mux_arbiter_4x1

Overview:
Round-robin arbiter that shares one 4:1 selection path between four requesters (a, b, c, d). It grants exactly one requester at a time and drives the s1/s0 select pair. It also forwards the granted requester's data to y. It sits in front of the team's bitwise 4:1 mux cell and replaces hand-driven select lines with a fair, bounded-hold schedule.

Parameters:
W, 1, data width of each input lane and of y
MAX_HOLD, 8, maximum consecutive cycles one requester keeps the grant while others wait (legal range 1..255)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  4  request vector; bit0=a, bit1=b, bit2=c, bit3=d
din_a  input  W  lane a data
din_b  input  W  lane b data
din_c  input  W  lane c data
din_d  input  W  lane d data
grant  output  4  one-hot registered grant, same bit order as req
s1  output  1  select MSB, registered
s0  output  1  select LSB, registered
busy  output  1  high while any grant is held
y  output  W  selected lane data

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - grant=0, s1=0, s0=0, busy=0, y=0.
  - Priority pointer ptr=0, so a has highest priority.
  - Hold counter cnt=0. State=IDLE.
- Select encoding: s1s0 = 00 for a, 01 for b, 10 for c, 11 for d.
- y is combinational from the registered select:
  - y = (a&~s1&~s0)|(b&~s1&s0)|(c&s1&~s0)|(d&s1&s0), applied per bit, gated by busy.
  - y = 0 whenever busy=0.
- Winner pick: scan req starting at index ptr, going ptr, ptr+1, ... mod 4. The first set bit wins.
- State IDLE:
  - If req != 0: next edge enters GRANT with grant=onehot(winner), {s1,s0}=winner, busy=1, cnt=1, ptr=winner+1 mod 4.
  - Otherwise hold all outputs at 0.
  - Latency: req sampled high at edge n gives grant visible after edge n (one cycle).
- State GRANT, current owner g:
  - req[g]=1 and cnt<MAX_HOLD: keep grant; cnt+1.
  - req[g]=0 and another request pending: switch directly to the next winner on the same edge, with no idle bubble. cnt=1; ptr updated.
  - req[g]=0 and no other request: go to IDLE. grant=0, busy=0, s1/s0 keep their last value.
  - cnt==MAX_HOLD, req[g]=1, and others pending: forced rotation to the next winner (g is excluded because ptr=g+1). cnt=1.
  - cnt==MAX_HOLD, req[g]=1, no others pending: keep grant; cnt=1.
- Simultaneous release and new request on the same edge: the releasing requester's bit is ignored; the pick uses the current req.
- Requests appearing mid-grant are not granted until release or timeout. No request is lost while it stays asserted.
- cnt width: clog2(MAX_HOLD+1). It never wraps because it reloads to 1.
- Invariants: grant is always one-hot or zero; busy == |grant; {s1,s0} matches the grant index whenever busy=1.

Decomposition:
- Package rr_mux_pkg holds:
  - state enum {IDLE, GRANT}
  - select constants SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11
  - function idx_to_onehot
- Sub-module rr_pick4: combinational (req[3:0], ptr[1:0], mask[3:0]) to (winner[1:0], found). It is reused for both the idle pick and the rotation pick.
- The output data path is the team's bitwise 4:1 mux cell, generated W times.

Test Plan:
- Reset mid-grant: grant=0100, drop rst_n asynchronously -> grant=0000, busy=0, y=0 immediately. After release, req=1111 -> grant=0001 (a).
- Single requester: req=0100, din_c=1 -> after 1 edge grant=0100, s1s0=10, y=1. Drop req -> next edge busy=0, y=0.
- Round-robin: req=1111 held, MAX_HOLD=2 -> grant sequence a,a,b,b,c,c,d,d,a, each owner for exactly 2 cycles.
- Back-to-back handoff: grant a, req=0011, then req[0] drops -> next edge grant=0010 with busy never deasserting.
- Lone hog: req=1000 held for 20 cycles, MAX_HOLD=8 -> grant stays 1000 and cnt reloads to 1 after cycles 8 and 16. Assert req[1] at cycle 10 -> grant=0010 at the edge where cnt==8.
- Invariant sweep: random req for 10k cycles -> grant always one-hot or zero, busy==|grant, {s1,s0} matches the grant index, and no asserted requester waits more than 3*MAX_HOLD+3 cycles.
